// File: rtl/byte_word_pkg.sv
// -----------------------------------------------------------------------------
// byte_word_pkg
// Shared definitions for the byte<->word conversion blocks.
//   BYTE_W        : width of one byte lane
//   out_state_e   : EMPTY/FULL state of an output holding register
//   lanes()       : number of byte lanes in a word of a given width
//   lane_lo()     : bit offset of byte lane idx, honouring the lane order
// -----------------------------------------------------------------------------
package byte_word_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic int lanes(input int width);
        return width / BYTE_W;
    endfunction

    // Lane 0 is the first byte of a word. With msb_first it occupies the top
    // lane, otherwise the bottom lane.
    function automatic int lane_lo(input int idx, input bit msb_first, input int n_lanes);
        return msb_first ? (n_lanes - 1 - idx) * BYTE_W : idx * BYTE_W;
    endfunction

endpackage

// File: rtl/byte_word_outreg.sv
// -----------------------------------------------------------------------------
// byte_word_outreg
// Output holding register with a valid/ready handshake (EMPTY/FULL).
// A load while FULL and being consumed in the same cycle keeps the register
// FULL with the new contents, so a steady stream sees no bubble.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_load        : capture i_word/i_nbytes/i_last (caller only loads when
//                   o_can_load is high)
//   i_word        : word to hold
//   i_nbytes      : number of valid bytes in i_word
//   i_last        : word closes a packet
//   i_ready       : downstream accepts the held word
//   o_word        : held word
//   o_nbytes      : held byte count
//   o_last        : held last flag
//   o_valid       : register is FULL
//   o_can_load    : a load this cycle would not overwrite an unconsumed word
// -----------------------------------------------------------------------------
module byte_word_outreg
    import byte_word_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NB_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic [NB_W-1:0]  i_nbytes,
    input  logic             i_last,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_word,
    output logic [NB_W-1:0]  o_nbytes,
    output logic             o_last,
    output logic             o_valid,
    output logic             o_can_load
);

    out_state_e       r_state;
    out_state_e       w_state_next;
    logic [WIDTH-1:0] r_word;
    logic [NB_W-1:0]  r_nbytes;
    logic             r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            OUT_EMPTY: begin
                if (i_load) begin
                    w_state_next = OUT_FULL;
                end
            end
            OUT_FULL: begin
                // A fresh load wins over draining: consume + load stays FULL.
                if (i_load) begin
                    w_state_next = OUT_FULL;
                end else if (i_ready) begin
                    w_state_next = OUT_EMPTY;
                end
            end
            default: w_state_next = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word   <= '0;
            r_nbytes <= '0;
            r_last   <= 1'b0;
        end else if (i_load) begin
            r_word   <= i_word;
            r_nbytes <= i_nbytes;
            r_last   <= i_last;
        end
    end

    assign o_word     = r_word;
    assign o_nbytes   = r_nbytes;
    assign o_last     = r_last;
    assign o_valid    = (r_state == OUT_FULL);
    assign o_can_load = !(o_valid && !i_ready);

endmodule

// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Reassembles an 8-bit byte stream into WIDTH-bit words. Bytes fill an
// accumulator; a word is closed by its last lane or by in_last and moved into
// a separate output register, so filling continues while a word waits.
// Parameters:
//   WIDTH     : output word width (multiple of 8, >= 16)
//   MSB_FIRST : 1 = first byte lands in the top lane, 0 = bottom lane
//   TIMEOUT   : idle cycles before a partial word is flushed (only with the
//               BYTE_WORD_PACKER_TIMEOUT_EN macro defined)
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_byte    : incoming byte
//   in_valid   : in_byte valid
//   in_last    : accepted byte ends a packet (forces a partial word out)
//   in_ready   : packer accepts a byte this cycle
//   out_word   : assembled word, unfilled lanes zero
//   out_nbytes : valid bytes in out_word
//   out_last   : word was closed by in_last
//   out_valid  : out_word valid
//   out_ready  : consumer accepts out_word
// Optional feature macro: BYTE_WORD_PACKER_TIMEOUT_EN (partial-word flush).
// -----------------------------------------------------------------------------
module byte_word_packer
    import byte_word_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
`ifdef BYTE_WORD_PACKER_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_byte,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_word,
    output logic [$clog2(WIDTH/8):0]      out_nbytes,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int N     = lanes(WIDTH);
    localparam int CNT_W = $clog2(N);
    localparam int NB_W  = CNT_W + 1;

    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_merged;
    logic             w_accept;
    logic             w_close;
    logic             w_flush;
    logic             w_load;
    logic             w_can_load;
    logic [WIDTH-1:0] w_load_word;
    logic [NB_W-1:0]  w_load_nbytes;
    logic             w_load_last;

    assign w_accept = in_valid && w_can_load;
    assign w_close  = w_accept && ((r_cnt == CNT_W'(N - 1)) || in_last);

    // Accumulator with the incoming byte dropped into lane r_cnt. Lanes past
    // r_cnt are still zero because the accumulator is cleared on every close.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            localparam int LO = lane_lo(gi, MSB_FIRST, N);
            assign w_merged[LO +: BYTE_W] = (r_cnt == CNT_W'(gi)) ? in_byte
                                                                  : r_acc[LO +: BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_close || w_flush) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_merged;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef BYTE_WORD_PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    // Counts idle cycles while a partial word is pending, saturating at
    // TIMEOUT-1; the flush fires on the TIMEOUT-th idle cycle and is held
    // off while the output register cannot take a word.
    logic [IDLE_W-1:0] r_idle;

    assign w_flush = (r_cnt != '0) && !w_accept && w_can_load
                     && (r_idle >= IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_accept || w_flush) begin
            r_idle <= '0;
        end else if ((r_cnt != '0) && (r_idle < IDLE_W'(TIMEOUT - 1))) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    assign w_load        = w_close || w_flush;
    assign w_load_word   = w_close ? w_merged : r_acc;
    assign w_load_nbytes = w_close ? ({1'b0, r_cnt} + NB_W'(1)) : {1'b0, r_cnt};
    assign w_load_last   = w_close && in_last;

    byte_word_outreg #(
        .WIDTH (WIDTH),
        .NB_W  (NB_W)
    ) u_outreg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_word     (w_load_word),
        .i_nbytes   (w_load_nbytes),
        .i_last     (w_load_last),
        .i_ready    (out_ready),
        .o_word     (out_word),
        .o_nbytes   (out_nbytes),
        .o_last     (out_last),
        .o_valid    (out_valid),
        .o_can_load (w_can_load)
    );

    // Worst-case stall: any byte waits while a held word is not draining.
    assign in_ready = w_can_load;

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

    localparam int TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_m, in_ready_l;
    logic [31:0] out_word_m, out_word_l;
    logic [2:0]  out_nbytes_m, out_nbytes_l;
    logic        out_last_m, out_last_l;
    logic        out_valid_m, out_valid_l;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] wm;
        logic [31:0] wl;
        int          n;
        bit          last;
    } exp_t;

    always #5 clk = ~clk;

    byte_word_packer #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_m), .out_word(out_word_m), .out_nbytes(out_nbytes_m),
        .out_last(out_last_m), .out_valid(out_valid_m), .out_ready(out_ready)
    );

    byte_word_packer #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_l), .out_word(out_word_l), .out_nbytes(out_nbytes_l),
        .out_last(out_last_l), .out_valid(out_valid_l), .out_ready(out_ready)
    );

    // Reference packing: byte i of a word goes to lane i counted from the top
    // (msb) or from the bottom.
    function automatic logic [31:0] pack(input logic [7:0] b[$], input bit msb);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < b.size(); i++) begin
            if (msb) w = w | ({24'h0, b[i]} << (8 * (3 - i)));
            else     w = w | ({24'h0, b[i]} << (8 * i));
        end
        return w;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int k;
        in_byte  = b;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        k = 0;
        while (!in_ready_m && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            total++; bad++;
            $display("FAIL send_byte_wait got in_ready=0 for 50 cycles want 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid_m !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid_m); end
        total++; if (out_word_m !== 32'h0) begin bad++; $display("FAIL reset_word got %h want 0", out_word_m); end
        total++; if (out_nbytes_m !== 3'd0) begin bad++; $display("FAIL reset_nbytes got %0d want 0", out_nbytes_m); end
        total++; if (out_last_m !== 1'b0) begin bad++; $display("FAIL reset_last got %b want 0", out_last_m); end
        total++; if (in_ready_m !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready_m); end
        $display("reset: valid=%b word=%h", out_valid_m, out_word_m);
        @(posedge clk); #1;
    endtask

    task automatic test_msb_word();
        apply_reset();
        out_ready = 1'b1;
        send_byte(8'h83, 1'b0); send_byte(8'hCA, 1'b0);
        send_byte(8'hBF, 1'b0); send_byte(8'hE0, 1'b0);
        @(negedge clk);
        total++; if (out_valid_m !== 1'b1) begin bad++; $display("FAIL msb_valid got %b want 1", out_valid_m); end
        total++; if (out_word_m !== 32'h83CABFE0) begin bad++; $display("FAIL msb_word got %h want 83cabfe0", out_word_m); end
        total++; if (out_nbytes_m !== 3'd4) begin bad++; $display("FAIL msb_nbytes got %0d want 4", out_nbytes_m); end
        total++; if (out_last_m !== 1'b0) begin bad++; $display("FAIL msb_last got %b want 0", out_last_m); end
        $display("msb word %h nbytes=%0d last=%b", out_word_m, out_nbytes_m, out_last_m);
        @(negedge clk);
        total++; if (out_valid_m !== 1'b0) begin bad++; $display("FAIL msb_one_cycle got valid=%b want 0", out_valid_m); end
        @(posedge clk); #1;
    endtask

    task automatic test_lsb_word();
        apply_reset();
        out_ready = 1'b1;
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0); send_byte(8'h78, 1'b0);
        @(negedge clk);
        total++; if (out_word_l !== 32'h78563412) begin bad++; $display("FAIL lsb_word got %h want 78563412", out_word_l); end
        total++; if (out_word_m !== 32'h12345678) begin bad++; $display("FAIL lsb_msb_word got %h want 12345678", out_word_m); end
        $display("lsb word %h msb word %h", out_word_l, out_word_m);
        @(posedge clk); #1;
    endtask

    task automatic test_last_partial();
        apply_reset();
        out_ready = 1'b1;
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b1);
        @(negedge clk);
        total++; if (out_word_m !== 32'hAABB0000) begin bad++; $display("FAIL partial_word got %h want aabb0000", out_word_m); end
        total++; if (out_word_l !== 32'h0000BBAA) begin bad++; $display("FAIL partial_word_lsb got %h want 0000bbaa", out_word_l); end
        total++; if (out_nbytes_m !== 3'd2) begin bad++; $display("FAIL partial_nbytes got %0d want 2", out_nbytes_m); end
        total++; if (out_last_m !== 1'b1) begin bad++; $display("FAIL partial_last got %b want 1", out_last_m); end
        $display("partial word %h nbytes=%0d last=%b", out_word_m, out_nbytes_m, out_last_m);
        @(posedge clk); #1;
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b1);
        @(negedge clk);
        total++; if (out_word_m !== 32'h01020304) begin bad++; $display("FAIL after_partial_word got %h want 01020304", out_word_m); end
        total++; if (out_nbytes_m !== 3'd4) begin bad++; $display("FAIL after_partial_nbytes got %0d want 4", out_nbytes_m); end
        total++; if (out_last_m !== 1'b1) begin bad++; $display("FAIL full_last got %b want 1", out_last_m); end
        $display("next word %h nbytes=%0d last=%b", out_word_m, out_nbytes_m, out_last_m);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        int idx;
        apply_reset();
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid = (idx < 8);
            in_byte  = 8'(idx + 1);
            if (cyc == 14) out_ready = 1'b1;
            @(negedge clk);
            if (cyc == 10) begin
                total++; if (in_ready_m !== 1'b0) begin bad++; $display("FAIL b2b_stall got in_ready=%b want 0", in_ready_m); end
                total++; if (out_word_m !== 32'h01020304) begin bad++; $display("FAIL b2b_hold got %h want 01020304", out_word_m); end
                total++; if (idx != 4) begin bad++; $display("FAIL b2b_accepted got %0d want 4", idx); end
            end
            if (cyc == 13) begin
                total++; if (out_valid_m !== 1'b1 || out_word_m !== 32'h01020304) begin
                    bad++; $display("FAIL b2b_stable got valid=%b word=%h want 1 01020304", out_valid_m, out_word_m);
                end
            end
            if (out_valid_m && out_ready) got.push_back(out_word_m);
            if (in_valid && in_ready_m) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++; if (got.size() != 2) begin bad++; $display("FAIL b2b_count got %0d want 2", got.size()); end
        if (got.size() >= 2) begin
            total++; if (got[0] !== 32'h01020304) begin bad++; $display("FAIL b2b_word0 got %h want 01020304", got[0]); end
            total++; if (got[1] !== 32'h05060708) begin bad++; $display("FAIL b2b_word1 got %h want 05060708", got[1]); end
            $display("b2b words %h %h", got[0], got[1]);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b1;
        send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0); send_byte(8'hBE, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        @(negedge clk);
        total++; if (out_word_m !== 32'h11223344) begin bad++; $display("FAIL rstmid_word got %h want 11223344", out_word_m); end
        total++; if (out_nbytes_m !== 3'd4) begin bad++; $display("FAIL rstmid_nbytes got %0d want 4", out_nbytes_m); end
        $display("reset-mid word %h", out_word_m);
        @(posedge clk); #1;
    endtask

    task automatic test_random_stream();
        exp_t        eq[$];
        exp_t        e;
        logic [7:0]  pq[$];
        int          idle;
        int          words;
        bit          can_load;
        apply_reset();
        idle  = 0;
        words = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            if (cyc < 860) begin
                in_valid  = ($urandom % 4) != 0;
                in_byte   = 8'($urandom);
                in_last   = ($urandom % 8) == 0;
                out_ready = ($urandom % 3) != 0;
            end else begin
                in_valid  = 1'b0;
                in_last   = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            total++; if (out_valid_m !== (eq.size() != 0)) begin
                bad++; $display("FAIL rnd_valid got %b want %b", out_valid_m, eq.size() != 0);
            end
            can_load = !(eq.size() != 0 && !out_ready);
            total++; if (in_ready_m !== can_load) begin
                bad++; $display("FAIL rnd_in_ready got %b want %b", in_ready_m, can_load);
            end
            if (eq.size() != 0 && out_ready) begin
                e = eq.pop_front();
                total++; if (out_word_m !== e.wm || out_word_l !== e.wl || out_nbytes_m !== 3'(e.n) || out_last_m !== e.last) begin
                    bad++;
                    $display("FAIL rnd_word got %h/%h n=%0d last=%b want %h/%h n=%0d last=%b",
                             out_word_m, out_word_l, out_nbytes_m, out_last_m, e.wm, e.wl, e.n, e.last);
                end
                words++;
                $display("rnd word %h nbytes=%0d last=%b", out_word_m, out_nbytes_m, out_last_m);
            end
            if (in_valid && can_load) begin
                pq.push_back(in_byte);
                idle = 0;
                if (pq.size() == 4 || in_last) begin
                    e.wm = pack(pq, 1'b1); e.wl = pack(pq, 1'b0);
                    e.n = pq.size(); e.last = in_last;
                    eq.push_back(e);
                    pq.delete();
                end
            end else if (pq.size() != 0) begin
`ifdef BYTE_WORD_PACKER_TIMEOUT_EN
                if (idle >= TB_TIMEOUT - 1 && can_load) begin
                    e.wm = pack(pq, 1'b1); e.wl = pack(pq, 1'b0);
                    e.n = pq.size(); e.last = 1'b0;
                    eq.push_back(e);
                    pq.delete();
                    idle = 0;
                end else begin
                    idle++;
                end
`else
                idle++;
`endif
            end
            @(posedge clk); #1;
        end
        total++; if (words < 50) begin bad++; $display("FAIL rnd_word_count got %0d want >=50", words); end
    endtask

`ifdef BYTE_WORD_PACKER_TIMEOUT_EN
    task automatic test_timeout();
        int first;
        logic [31:0] wm, wl;
        logic [2:0]  nb;
        logic        lst;
        apply_reset();
        out_ready = 1'b1;
        send_byte(8'h9C, 1'b0);
        first = -1;
        wm = '0; wl = '0; nb = '0; lst = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (out_valid_m && first < 0) begin
                first = k; wm = out_word_m; wl = out_word_l; nb = out_nbytes_m; lst = out_last_m;
            end
        end
        total++; if (first != TB_TIMEOUT + 1) begin bad++; $display("FAIL timeout_latency got %0d want %0d", first, TB_TIMEOUT + 1); end
        total++; if (wm !== 32'h9C000000) begin bad++; $display("FAIL timeout_word got %h want 9c000000", wm); end
        total++; if (wl !== 32'h0000009C) begin bad++; $display("FAIL timeout_word_lsb got %h want 0000009c", wl); end
        total++; if (nb !== 3'd1) begin bad++; $display("FAIL timeout_nbytes got %0d want 1", nb); end
        total++; if (lst !== 1'b0) begin bad++; $display("FAIL timeout_last got %b want 0", lst); end
        $display("timeout word %h after %0d cycles", wm, first);
        @(posedge clk); #1;
    endtask
`else
    task automatic test_no_timeout();
        int seen;
        apply_reset();
        out_ready = 1'b1;
        send_byte(8'h9C, 1'b0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid_m) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL no_timeout_emit got %0d want 0", seen); end
        @(posedge clk); #1;
        send_byte(8'h5A, 1'b1);
        @(negedge clk);
        total++; if (out_word_m !== 32'h9C5A0000) begin bad++; $display("FAIL no_timeout_word got %h want 9c5a0000", out_word_m); end
        total++; if (out_nbytes_m !== 3'd2) begin bad++; $display("FAIL no_timeout_nbytes got %0d want 2", out_nbytes_m); end
        $display("held partial word %h", out_word_m);
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_msb_word();
        test_lsb_word();
        test_last_partial();
        test_back_to_back();
        test_reset_mid();
`ifdef BYTE_WORD_PACKER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
